// File: rtl/rv32v_rf_wb_arbiter.sv
// rv32v_rf_wb_arbiter
//   Round-robin arbiter that shares the vector register file write port
//   among NUM_REQ writeback requesters. A multi-beat burst locks the grant
//   to one requester until its last beat is accepted. The write port outputs
//   are registered, so a beat appears at the register file one cycle after
//   it is accepted.
//
// Ports
//   CLK, nRST        clock, asynchronous active-low reset
//   req_valid[i]     requester i has a beat
//   req_ready[i]     beat of requester i accepted (with req_valid[i])
//   req_last[i]      beat is the final beat of the burst
//   req_rd           packed 5-bit destination register per requester
//   req_wdata        packed NUM_LANES*32-bit data per requester
//   req_wen          packed WEN_WIDTH-bit write mask per requester
//   rf_w_data        registered write data to the register file
//   rf_rd            registered destination register
//   rf_wen           registered write enable; zero means no write
//   grant_idx        index of the last accepted requester
//   busy             high while a burst is locked
module rv32v_rf_wb_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned WEN_WIDTH = 4,
    localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_last,
    input  logic [NUM_REQ*5-1:0]              req_rd,
    input  logic [NUM_REQ*NUM_LANES*32-1:0]   req_wdata,
    input  logic [NUM_REQ*WEN_WIDTH-1:0]      req_wen,
    output logic [NUM_LANES*32-1:0]           rf_w_data,
    output logic [4:0]                        rf_rd,
    output logic [WEN_WIDTH-1:0]              rf_wen,
    output logic [IDX_W-1:0]                  grant_idx,
    output logic                              busy
);

    localparam int unsigned DW = NUM_LANES * 32;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [DW-1:0]          r_w_data;
    logic [4:0]             r_rd;
    logic [WEN_WIDTH-1:0]   r_wen;
    logic [IDX_W-1:0]       r_grant;
    logic                   r_busy;

    logic [4:0]             w_rd_arr  [NUM_REQ];
    logic [DW-1:0]          w_wd_arr  [NUM_REQ];
    logic [WEN_WIDTH-1:0]   w_wen_arr [NUM_REQ];

    logic                   w_found;
    logic [IDX_W-1:0]       w_winner;
    logic [IDX_W:0]         w_sum;
    logic [IDX_W-1:0]       w_idx;
    logic [IDX_W-1:0]       w_sel;
    logic                   w_sel_ok;
    logic                   w_accept;
    logic                   w_last;
    logic [IDX_W-1:0]       w_next_ptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_rd_arr[g]  = req_rd[g*5 +: 5];
        assign w_wd_arr[g]  = req_wdata[g*DW +: DW];
        assign w_wen_arr[g] = req_wen[g*WEN_WIDTH +: WEN_WIDTH];
    end

    // First valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ))
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // While locked the owner keeps ready even with valid low, so gaps
    // inside a burst never let another requester in.
    always_comb begin
        w_sel      = (r_state == ST_LOCKED) ? r_owner : w_winner;
        w_sel_ok   = (r_state == ST_LOCKED) || w_found;
        req_ready  = w_sel_ok ? (NUM_REQ'(1) << w_sel) : '0;
        w_accept   = w_sel_ok && req_valid[w_sel];
        w_last     = req_last[w_sel];
        w_next_ptr = (w_sel == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_w_data <= '0;
            r_rd     <= '0;
            r_wen    <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_wen <= '0;
            if (w_accept) begin
                r_w_data <= w_wd_arr[w_sel];
                r_rd     <= w_rd_arr[w_sel];
                r_wen    <= w_wen_arr[w_sel];
                r_grant  <= w_sel;
                if (w_last) begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                end else begin
                    r_state  <= ST_LOCKED;
                    r_owner  <= w_sel;
                    r_busy   <= 1'b1;
                end
            end
        end
    end

    assign rf_w_data = r_w_data;
    assign rf_rd     = r_rd;
    assign rf_wen    = r_wen;
    assign grant_idx = r_grant;
    assign busy      = r_busy;

endmodule

// File: tb/tb_rv32v_rf_wb_arbiter.sv
// tb_rv32v_rf_wb_arbiter
//   Directed-vector bench for rv32v_rf_wb_arbiter with NUM_REQ=3,
//   NUM_LANES=2, WEN_WIDTH=4. Inputs change 1ns after the rising edge,
//   req_ready is checked at the falling edge and the registered write port
//   1ns after the rising edge.
module tb_rv32v_rf_wb_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned NL = 2;
    localparam int unsigned WW = 4;

    logic               CLK;
    logic               nRST;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      req_last;
    logic [NR*5-1:0]    req_rd;
    logic [NR*NL*32-1:0] req_wdata;
    logic [NR*WW-1:0]   req_wen;
    logic [NL*32-1:0]   rf_w_data;
    logic [4:0]         rf_rd;
    logic [WW-1:0]      rf_wen;
    logic [1:0]         grant_idx;
    logic               busy;

    logic [4:0]         tb_rd  [NR];
    logic [NL*32-1:0]   tb_wd  [NR];
    logic [WW-1:0]      tb_wen [NR];

    int n_checks;
    int n_errors;

    rv32v_rf_wb_arbiter #(
        .NUM_REQ   (NR),
        .NUM_LANES (NL),
        .WEN_WIDTH (WW)
    ) u_dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_last  (req_last),
        .req_rd    (req_rd),
        .req_wdata (req_wdata),
        .req_wen   (req_wen),
        .rf_w_data (rf_w_data),
        .rf_rd     (rf_rd),
        .rf_wen    (rf_wen),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        req_rd    = '0;
        req_wdata = '0;
        req_wen   = '0;
        for (int i = 0; i < NR; i++) begin
            req_rd[i*5 +: 5]           = tb_rd[i];
            req_wdata[i*NL*32 +: NL*32] = tb_wd[i];
            req_wen[i*WW +: WW]        = tb_wen[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: check ready at the falling edge, then advance past the
    // rising edge so the caller sees the registered result.
    task automatic step(input logic [NR-1:0] exp_ready, input string tag);
        @(negedge CLK);
        check(tag, 64'(req_ready), 64'(exp_ready));
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        nRST      = 1'b0;
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) begin
            tb_rd[i]  = '0;
            tb_wd[i]  = '0;
            tb_wen[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_wen",   64'(rf_wen),    64'h0);
        check("rst_rd",    64'(rf_rd),     64'h0);
        check("rst_wdata", 64'(rf_w_data), 64'h0);
        check("rst_grant", 64'(grant_idx), 64'h0);
        check("rst_busy",  64'(busy),      64'h0);
        check("rst_ready", 64'(req_ready), 64'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Single beat from requester 0
        tb_rd[0]  = 5'd5;
        tb_wd[0]  = 64'h0000000A_0000000B;
        tb_wen[0] = 4'hF;
        req_valid = 3'b001;
        req_last  = 3'b001;
        step(3'b001, "t1_ready");
        check("t1_rd",    64'(rf_rd),     64'd5);
        check("t1_wen",   64'(rf_wen),    64'hF);
        check("t1_wdata", 64'(rf_w_data), 64'h0000000A_0000000B);
        check("t1_grant", 64'(grant_idx), 64'd0);
        check("t1_busy",  64'(busy),      64'd0);

        // No request: wen drops, data/rd/grant hold
        req_valid = 3'b000;
        step(3'b000, "idle_ready");
        check("idle_wen",   64'(rf_wen),    64'h0);
        check("idle_rd",    64'(rf_rd),     64'd5);
        check("idle_wdata", 64'(rf_w_data), 64'h0000000A_0000000B);
        check("idle_grant", 64'(grant_idx), 64'd0);

        // Pointer moved to 1: requester 1 beats requester 0
        tb_rd[1]  = 5'd7;
        tb_wen[1] = 4'h3;
        req_valid = 3'b011;
        req_last  = 3'b011;
        step(3'b010, "t1_ptr_ready");
        check("t1_ptr_grant", 64'(grant_idx), 64'd1);
        check("t1_ptr_rd",    64'(rf_rd),     64'd7);

        // Round-robin fairness from reset
        do_reset();
        for (int i = 0; i < NR; i++) begin
            tb_rd[i]  = 5'(10 + i);
            tb_wen[i] = 4'(i + 1);
            tb_wd[i]  = 64'(i + 1) * 64'h11111111_11111111;
        end
        req_valid = 3'b111;
        req_last  = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step(3'(1 << (k % 3)), "rr_ready");
            check("rr_grant", 64'(grant_idx), 64'(k % 3));
            check("rr_wen",   64'(rf_wen),    64'((k % 3) + 1));
            check("rr_rd",    64'(rf_rd),     64'(10 + (k % 3)));
        end

        // Burst lock: pointer to 1 first, then req1 bursts 4 beats
        req_valid = 3'b001;
        step(3'b001, "pre_burst_ready");
        check("pre_burst_busy", 64'(busy), 64'd0);
        req_valid = 3'b111;
        req_last  = 3'b101;
        for (int b = 0; b < 4; b++) begin
            tb_rd[1] = 5'(8 + b);
            if (b == 3) req_last = 3'b111;
            step(3'b010, "burst_ready");
            check("burst_rd",    64'(rf_rd),     64'(8 + b));
            check("burst_grant", 64'(grant_idx), 64'd1);
            check("burst_busy",  64'(busy),      64'(b < 3));
        end
        step(3'b100, "post_burst_ready");
        check("post_burst_grant", 64'(grant_idx), 64'd2);

        // Gap inside a burst owned by requester 0
        req_valid = 3'b111;
        req_last  = 3'b110;
        step(3'b001, "gap_start_ready");
        check("gap_start_busy", 64'(busy), 64'd1);
        req_valid = 3'b110;
        for (int g = 0; g < 2; g++) begin
            step(3'b001, "gap_ready");
            check("gap_wen",  64'(rf_wen), 64'h0);
            check("gap_busy", 64'(busy),   64'd1);
        end
        req_valid = 3'b111;
        req_last  = 3'b111;
        step(3'b001, "gap_end_ready");
        check("gap_end_wen",  64'(rf_wen), 64'h1);
        check("gap_end_busy", 64'(busy),   64'd0);

        // Zero-mask beat: accepted, no write, pointer still advances
        tb_rd[0]  = 5'd20;
        tb_wen[0] = 4'h0;
        req_valid = 3'b001;
        req_last  = 3'b111;
        step(3'b001, "zm_ready");
        check("zm_wen",   64'(rf_wen),    64'h0);
        check("zm_rd",    64'(rf_rd),     64'd20);
        check("zm_grant", 64'(grant_idx), 64'd0);
        req_valid = 3'b011;
        step(3'b010, "zm_ptr_ready");

        // Reset during beat 2 of a req2 burst
        tb_wen[2] = 4'h9;
        req_valid = 3'b100;
        req_last  = 3'b000;
        step(3'b100, "rstb_b1_ready");
        check("rstb_b1_busy", 64'(busy),   64'd1);
        check("rstb_b1_wen",  64'(rf_wen), 64'h9);
        #2;
        nRST = 1'b0;
        #1;
        check("rstb_async_wen",  64'(rf_wen), 64'h0);
        check("rstb_async_busy", 64'(busy),   64'd0);
        req_valid = 3'b000;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check("rstb_rel_busy", 64'(busy), 64'd0);
        req_valid = 3'b111;
        req_last  = 3'b111;
        step(3'b001, "rstb_after_ready");
        check("rstb_after_grant", 64'(grant_idx), 64'd0);
        check("rstb_after_busy",  64'(busy),      64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
